// File: rtl/pump_batch_controller.sv
// pump_batch_controller
//
// Preset-volume dispensing controller for the manual fuel-pump path. Three active-low
// preset buttons (200/500/1000 ml) are synchronised and debounced. An accepted press
// latches a target volume. After a tank-level check the pump relay is driven, and the
// pumped volume is metered by counting clock ticks at a fixed flow rate. The batch price
// is accumulated alongside the volume.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   btn_200/500/1000  raw preset buttons, active-low, asynchronous
//   enable        manual mode selected (level)
//   stop          operator stop switch (level, active-high)
//   tank_ml       current tank volume in ml
//   relay         pump relay drive, 1 = pumping (registered)
//   busy          high while pumping (registered)
//   done          one-cycle pulse on normal batch completion
//   fault         sticky insufficient-tank flag, cleared by the next accepted press
//   target_ml     latched batch target
//   dispensed_ml  ml pumped in the current/last batch
//   price_vnd     price of the current/last batch
module pump_batch_controller #(
    parameter int unsigned TICKS_PER_ML    = 20000,
    parameter int unsigned PRICE_PER_ML    = 25,
    parameter int unsigned MIN_TANK_ML     = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_200,
    input  logic        btn_500,
    input  logic        btn_1000,
    input  logic        enable,
    input  logic        stop,
    input  logic [15:0] tank_ml,
    output logic        relay,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [15:0] target_ml,
    output logic [15:0] dispensed_ml,
    output logic [16:0] price_vnd
);

    localparam int unsigned TickW = (TICKS_PER_ML > 1) ? $clog2(TICKS_PER_ML) : 1;
    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TickW-1:0] TickMax   = TickW'(TICKS_PER_ML - 1);
    localparam logic [DbW-1:0]   DbMax     = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [16:0]      PriceInc  = 17'(PRICE_PER_ML);
    localparam logic [16:0]      MinTank17 = 17'(MIN_TANK_ML);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StPump,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Button path: 2-FF synchroniser, debounce counter, press detector.
    // Bit 0 = 200 ml, bit 1 = 500 ml, bit 2 = 1000 ml.
    // ------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] db_q, db_d;
    logic [2:0] press_q, press_d;
    logic [DbW-1:0] db_cnt_q [3];
    logic [DbW-1:0] db_cnt_d [3];

    assign btn_raw = {btn_1000, btn_500, btn_200};

    // The counter tracks consecutive samples that disagree with the debounced level;
    // any agreeing sample restarts it, so bouncing shorter than the window is ignored.
    always_comb begin
        db_d    = db_q;
        press_d = '0;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    db_d[i]    = sync2_q[i];
                    press_d[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Buttons are active-low: the released level is 1.
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Batch FSM and metering
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [15:0]        target_q, target_d;
    logic [15:0]        dispensed_q, dispensed_d;
    logic [16:0]        price_q, price_d;
    logic               fault_q, fault_d;
    logic               relay_q, relay_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [16:0] required_ml;
    logic [15:0] dispensed_inc;
    logic        tank_short;
    logic        tank_reserve_hit;

    // 17-bit sum so a large target plus the reserve cannot wrap.
    assign required_ml      = {1'b0, target_q} + MinTank17;
    assign tank_short       = ({1'b0, tank_ml} < required_ml);
    assign tank_reserve_hit = ({1'b0, tank_ml} < MinTank17);
    assign dispensed_inc    = dispensed_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        target_d    = target_q;
        dispensed_d = dispensed_q;
        price_d     = price_q;
        fault_d     = fault_q;

        unique case (state_q)
            StIdle: begin
                if (enable && !stop && (press_q != 3'b000)) begin
                    if (press_q[0]) begin
                        target_d = 16'd200;
                    end else if (press_q[1]) begin
                        target_d = 16'd500;
                    end else begin
                        target_d = 16'd1000;
                    end
                    dispensed_d = '0;
                    price_d     = '0;
                    fault_d     = 1'b0;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (tank_short) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    tick_d  = '0;
                    state_d = StPump;
                end
            end
            StPump: begin
                // Aborts win over the metering increment in the same cycle.
                if (stop || !enable) begin
                    state_d = StIdle;
                end else if (tank_reserve_hit) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else if (tick_q == TickMax) begin
                    tick_d      = '0;
                    dispensed_d = dispensed_inc;
                    price_d     = price_q + PriceInc;
                    if (dispensed_inc == target_q) begin
                        state_d = StDone;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so relay tracks PUMP exactly.
        relay_d = (state_d == StPump);
        busy_d  = (state_d == StPump);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            target_q    <= '0;
            dispensed_q <= '0;
            price_q     <= '0;
            fault_q     <= 1'b0;
            relay_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            target_q    <= target_d;
            dispensed_q <= dispensed_d;
            price_q     <= price_d;
            fault_q     <= fault_d;
            relay_q     <= relay_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign relay        = relay_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign target_ml    = target_q;
    assign dispensed_ml = dispensed_q;
    assign price_vnd    = price_q;

endmodule
